// File: rtl/reaction_timer.sv
// Single reaction-test trial: random pre-stimulus delay, LED, then measure the
// player's reaction time in ms, flagging early presses and no-press timeouts.
module reaction_timer #(
  parameter int TICK_DIV     = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        btn,
  input  logic [9:0]  rand_num,
  output logic        led_stim,
  output logic        busy,
  output logic        done,
  output logic [13:0] result_ms,
  output logic        early,
  output logic        timeout
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [13:0]   MIN_D     = 14'(MIN_DELAY_MS);
  localparam logic [13:0]   TO_MS     = 14'(TIMEOUT_MS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STIM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   ms_q, ms_d;
  logic [13:0]   delay_q, delay_d;
  logic [13:0]   result_q, result_d;
  logic          early_q, early_d;
  logic          timeout_q, timeout_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tick;
  logic [13:0]   ms_inc;

  assign tick   = (presc_q == PRESC_MAX);
  assign ms_inc = ms_q + 14'd1;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    ms_d      = ms_q;
    delay_d   = delay_q;
    result_d  = result_q;
    early_d   = early_q;
    timeout_d = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !btn) begin
          delay_d   = MIN_D + {4'b0000, rand_num};
          presc_d   = '0;
          ms_d      = '0;
          result_d  = '0;
          early_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) ms_d = ms_inc;
        // A press beats a delay-expiry tick landing in the same cycle.
        if (btn) begin
          early_d  = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else if (tick && ms_inc == delay_q) begin
          presc_d = '0;
          ms_d    = '0;
          state_d = S_STIM;
        end
      end
      S_STIM: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) ms_d = ms_inc;
        if (btn) begin
          result_d = ms_q;
          state_d  = S_DONE;
        end else if (tick && ms_inc == TO_MS) begin
          timeout_d = 1'b1;
          result_d  = TO_MS;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave a flop directly.
    led_d  = (state_d == S_STIM);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      ms_q      <= '0;
      delay_q   <= '0;
      result_q  <= '0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      delay_q   <= delay_d;
      result_q  <= result_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign led_stim  = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result_ms = result_q;
  assign early     = early_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Randomized bench for reaction_timer; expected behaviour comes from a
// trial-level timeline model (LED edge, done edge, outcome) per accepted start.
module tb_reaction_timer;

  localparam int TD   = 4;
  localparam int MIND = 2;
  localparam int TO   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        btn = 1'b0;
  logic [9:0]  rand_num = '0;
  logic        led_stim, busy, done, early, timeout;
  logic [13:0] result_ms;

  int errors = 0;
  int checks = 0;

  reaction_timer #(.TICK_DIV(TD), .MIN_DELAY_MS(MIND), .TIMEOUT_MS(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .rand_num(rand_num),
    .led_stim(led_stim), .busy(busy), .done(done), .result_ms(result_ms),
    .early(early), .timeout(timeout)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"}, 32'(led_stim), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_res"}, 32'(result_ms), 0);
    check({tag, "_early"}, 32'(early), 0);
    check({tag, "_tmo"}, 32'(timeout), 0);
  endtask

  // press_at: edge index (relative to the accepting edge) at which btn is
  // first sampled high; 0 means never pressed.
  task automatic run_trial(input int rn, input int press_at, input bit noise);
    int led_edge, done_edge, exp_res;
    bit exp_early, exp_tmo, b;
    led_edge = (MIND + rn) * TD;
    if (press_at > 0 && press_at <= led_edge) begin
      exp_early = 1; exp_tmo = 0; exp_res = 0; done_edge = press_at;
    end else if (press_at > 0 && press_at <= led_edge + TO * TD) begin
      exp_early = 0; exp_tmo = 0; done_edge = press_at;
      exp_res = (press_at - led_edge - 1) / TD;
    end else begin
      exp_early = 0; exp_tmo = 1; exp_res = TO; done_edge = led_edge + TO * TD;
    end

    start = 1'b1;
    rand_num = 10'(rn);
    step();
    start = 1'b0;
    for (int k = 0; k <= done_edge + 1; k++) begin
      check("led", 32'(led_stim), 32'(k >= led_edge && k < done_edge));
      check("done", 32'(done), 32'(k == done_edge));
      check("busy", 32'(busy), 32'(k <= done_edge));
      if (k == 0) begin
        check("clr_res", 32'(result_ms), 0);
        check("clr_early", 32'(early), 0);
        check("clr_tmo", 32'(timeout), 0);
      end
      if (k >= done_edge) begin
        check("result", 32'(result_ms), 32'(exp_res));
        check("early", 32'(early), 32'(exp_early));
        check("timeout", 32'(timeout), 32'(exp_tmo));
      end
      if (k <= done_edge) begin
        b = (press_at > 0) && (k + 1 >= press_at) && (k + 1 <= done_edge);
        btn = b;
        // starts while busy (incl. the DONE cycle) must change nothing
        start = noise && ($urandom_range(0, 3) == 0);
        rand_num = 10'($urandom_range(0, 1023));
        step();
      end
    end
    start = 1'b0;
    btn = 1'b0;
  endtask

  task automatic random_trial();
    int rn, led_edge, kind, p;
    rn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 7));
    led_edge = (MIND + rn) * TD;
    kind = $urandom_range(0, 5);
    case (kind)
      0: p = 0;
      1: p = $urandom_range(1, led_edge);
      2: p = led_edge;
      3: p = led_edge + TO * TD;
      4: p = led_edge + 1;
      default: p = $urandom_range(led_edge + 1, led_edge + TO * TD);
    endcase
    run_trial(rn, p, 1'b1);
  endtask

  initial begin
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle");

    // directed scenarios
    run_trial(3, 30, 1'b0);         // normal: result 2
    run_trial(5, 6, 1'b0);          // early press
    run_trial(0, 0, 1'b0);          // timeout
    run_trial(0, 88, 1'b0);         // press on the timeout tick -> 19
    run_trial(3, 30, 1'b1);         // normal with busy-time start noise

    // start with button held in IDLE is refused
    run_trial(0, 0, 1'b0);
    btn = 1'b1;
    start = 1'b1;
    rand_num = 10'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("btn_block_busy", 32'(busy), 0);
      check("btn_block_tmo_hold", 32'(timeout), 1);
    end
    btn = 1'b0;
    start = 1'b0;

    // reset while the LED is lit
    start = 1'b1;
    rand_num = 10'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    check("pre_rst_led", 32'(led_stim), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("mid_rst");
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_done", 32'(done), 0);
      check("post_rst_busy", 32'(busy), 0);
    end
    run_trial(1, 0, 1'b0);          // LED 12 cycles after start

    // reset in IDLE clears held flags
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("idle_rst");

    for (int t = 0; t < 40; t++) random_trial();
    run_trial(1023, 0, 1'b1);       // largest delay

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
